// File: rtl/regfile_dump_unit_if.sv
// regfile_dump_unit_if: valid/ready word stream carrying dump words out of the debug readout engine.
interface regfile_dump_unit_if #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]  out_idx;
    logic              out_last;
    modport master (output out_valid, out_data, out_idx, out_last, input out_ready);
    modport slave  (input out_valid, out_data, out_idx, out_last, output out_ready);
endinterface

// File: rtl/regfile_dump_unit.sv
// regfile_dump_unit: on a halt_req rising edge, stalls the core and streams PC then R0..R(NUM_REGS-1).
// Define DUMP_CHECKSUM_EN to append an XOR checksum word after the last register.
module regfile_dump_unit #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3,
    parameter int IDX_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt_req,
    input  logic [DATA_W-1:0] pc_in,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              cpu_stall,
    output logic              dump_done,
    regfile_dump_unit_if.master s
);
    typedef enum logic [2:0] {IDLE, FREEZE, LOAD, SEND, DONE} state_t;
    state_t            state, state_nx;
    logic [IDX_W-1:0]  idx;
    logic              prev;
    logic              hs;
    logic [DATA_W-1:0] word;
`ifdef DUMP_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS + 1);
    logic [DATA_W-1:0] csum;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) csum <= '0;
        else if (state == FREEZE) csum <= '0;
        else if (state == LOAD) csum <= csum ^ word;
    end
    assign word = idx == '0 ? pc_in : idx == LAST ? csum : rd_data;
`else
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS);
    assign word = idx == '0 ? pc_in : rd_data;
`endif
    assign hs = s.out_valid & s.out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = (halt_req & ~prev) ? FREEZE : IDLE;
            FREEZE:  state_nx = LOAD;
            LOAD:    state_nx = SEND;
            SEND:    state_nx = hs ? (s.out_last ? DONE : LOAD) : SEND;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        cpu_stall = state != IDLE;
        dump_done = state == DONE;
        rd_addr   = (state == LOAD && idx != '0 && idx <= IDX_W'(NUM_REGS)) ? ADDR_W'(idx - 1'b1) : '0;
    end
    // Stream word registers only change on LOAD or on a handshake, so they hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev        <= 1'b0;
            idx         <= '0;
            s.out_valid <= 1'b0;
            s.out_data  <= '0;
            s.out_idx   <= '0;
            s.out_last  <= 1'b0;
        end else begin
            prev <= halt_req;
            if (state == FREEZE) idx <= '0;
            if (state == LOAD) begin
                s.out_valid <= 1'b1;
                s.out_data  <= word;
                s.out_idx   <= idx;
                s.out_last  <= idx == LAST;
            end
            if (state == SEND && hs) begin
                s.out_valid <= 1'b0;
                if (!s.out_last) idx <= idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_dump_unit.sv
// tb_regfile_dump_unit: randomized stimulus checked every cycle against a transaction-level dump model.
module tb_regfile_dump_unit;
    localparam int DATA_W = 32, NUM_REGS = 8, ADDR_W = 3, IDX_W = 4;
`ifdef DUMP_CHECKSUM_EN
    localparam int NWORDS = NUM_REGS + 2;
`else
    localparam int NWORDS = NUM_REGS + 1;
`endif
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
        logic              last;
    } word_t;

    logic              clk = 0, rst_n = 0, halt_req = 0;
    logic [DATA_W-1:0] pc_in = 0;
    logic [DATA_W-1:0] rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              cpu_stall, dump_done;
    logic [DATA_W-1:0] regs [NUM_REGS];

    regfile_dump_unit_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();
    regfile_dump_unit #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .pc_in(pc_in),
        .rd_addr(rd_addr), .rd_data(rd_data), .cpu_stall(cpu_stall),
        .dump_done(dump_done), .s(bus)
    );

    always #5 clk = ~clk;
    assign rd_data = regs[rd_addr];

    int checks = 0, errors = 0;
    task automatic chk(string name, logic [DATA_W-1:0] act, logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a dump is a list of words fixed at the trigger; timing follows from trigger/handshake events.
    word_t exp_q[$];
    word_t got[$];
    bit    m_busy = 0, m_done = 0, m_prev = 0;
    int    m_wait = 0;
    int    dones = 0;
    logic              pv = 0, pl = 0;
    logic [DATA_W-1:0] pd = 0;
    logic [IDX_W-1:0]  pi = 0;

    function automatic void build_dump();
        logic [DATA_W-1:0] x = '0;
        word_t w;
        for (int i = 0; i <= NUM_REGS; i++) begin
            if (i == 0) w.data = pc_in;
            else w.data = regs[i-1];
            w.idx  = IDX_W'(i);
            w.last = (i == NWORDS - 1);
            x ^= w.data;
            exp_q.push_back(w);
        end
`ifdef DUMP_CHECKSUM_EN
        w.data = x;
        w.idx  = IDX_W'(NUM_REGS + 1);
        w.last = 1'b1;
        exp_q.push_back(w);
`endif
    endfunction

    always @(posedge clk) begin
        bit hs, exp_v;
        word_t w;
        #1;
        if (!rst_n) begin
            chk("rst_stall", cpu_stall, 0);
            chk("rst_valid", bus.out_valid, 0);
            chk("rst_data", bus.out_data, 0);
            chk("rst_idx", bus.out_idx, 0);
            chk("rst_last", bus.out_last, 0);
            chk("rst_done", dump_done, 0);
            chk("rst_addr", rd_addr, 0);
            m_busy = 0; m_done = 0; m_wait = 0; m_prev = 0;
            exp_q.delete();
        end else begin
            hs = pv & bus.out_ready;
            if (hs) begin
                w.data = pd; w.idx = pi; w.last = pl;
                got.push_back(w);
            end
            if (!m_busy) begin
                if (halt_req && !m_prev) begin
                    m_busy = 1; m_wait = 2;
                    build_dump();
                end
            end else if (m_done) begin
                m_busy = 0; m_done = 0;
            end else if (hs) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (exp_q.size() == 0) m_done = 1;
                else m_wait = 1;
            end else if (m_wait > 0) m_wait--;
            m_prev = halt_req;
            exp_v = m_busy && !m_done && m_wait == 0;
            chk("stall", cpu_stall, m_busy);
            chk("dump_done", dump_done, m_done);
            chk("valid", bus.out_valid, exp_v);
            if (exp_v && exp_q.size() > 0) begin
                chk("data", bus.out_data, exp_q[0].data);
                chk("idx", bus.out_idx, exp_q[0].idx);
                chk("last", bus.out_last, exp_q[0].last);
            end
            if (dump_done) dones++;
        end
        pv = rst_n & bus.out_valid;
        pd = bus.out_data; pi = bus.out_idx; pl = bus.out_last;
    end

    task automatic load_basic();
        pc_in = 32'h10;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = DATA_W'(i + 1);
    endtask

    task automatic wait_done(int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #2;
            seen = dump_done;
        end
        chk("dump_done_seen", seen, 1);
        @(negedge clk);
    endtask

    task automatic wait_word(int k);
        for (int i = 0; i < 100 && !(bus.out_valid && bus.out_idx == IDX_W'(k)); i++) @(negedge clk);
        chk("word_reached", bus.out_idx, k);
    endtask

    initial begin
        int n, nl, base;
        bus.out_ready = 0;
        load_basic();
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // abort on reset during the third word
        bus.out_ready = 1;
        got.delete();
        halt_req = 1; @(negedge clk); halt_req = 0;
        wait_word(2);
        rst_n = 0; #1;
        chk("abort_stall", cpu_stall, 0);
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_data", bus.out_data, 0);
        chk("abort_idx", bus.out_idx, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        repeat (30) @(negedge clk);
        chk("abort_words", got.size(), 2);

        // basic dump with latency; halt_req stays high afterwards
        got.delete(); dones = 0;
        halt_req = 1;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!bus.out_valid && n < 10);
        chk("latency", n, 3);
        wait_done(200);
        chk("nwords", got.size(), NWORDS);
        chk("w0_pc", got[0].data, 32'h10);
        chk("w1_r0", got[1].data, 1);
        chk("w8_r7", got[8].data, 8);
        chk("w8_idx", got[8].idx, 8);
        nl = 0;
        foreach (got[i]) nl += int'(got[i].last);
        chk("last_count", nl, 1);
        chk("last_pos", got[NWORDS-1].last, 1);
`ifdef DUMP_CHECKSUM_EN
        chk("csum", got[9].data, 32'h18);
        chk("csum_idx", got[9].idx, 9);
`endif
        repeat (20) @(negedge clk);
        chk("hold_no_retrigger", got.size(), NWORDS);
        chk("done_pulses", dones, 1);
        halt_req = 0; @(negedge clk); halt_req = 1;
        wait_done(200);
        chk("retrigger_words", got.size(), 2 * NWORDS);
        halt_req = 0;
        @(negedge clk);

        // backpressure at idx 3 plus an ignored halt edge mid-dump
        got.delete();
        halt_req = 1; @(negedge clk); halt_req = 0;
        wait_word(3);
        bus.out_ready = 0;
        repeat (5) begin
            @(negedge clk);
            halt_req = ~halt_req;
            chk("bp_valid", bus.out_valid, 1);
            chk("bp_data", bus.out_data, 3);
        end
        halt_req = 1;
        bus.out_ready = 1;
        wait_done(200);
        repeat (15) @(negedge clk);
        chk("bp_words", got.size(), NWORDS);
        chk("bp_w3", got[3].data, 3);
        halt_req = 0;

        // randomized ready, halt and register contents
        got.delete(); dones = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            bus.out_ready = $urandom_range(0, 3) != 0;
            if ($urandom_range(0, 11) == 0) halt_req = ~halt_req;
            if (!cpu_stall && $urandom_range(0, 3) == 0) begin
                pc_in = $urandom;
                regs[$urandom_range(0, NUM_REGS-1)] = $urandom;
            end
        end
        halt_req = 0; bus.out_ready = 1;
        for (int i = 0; i < 100 && cpu_stall; i++) @(negedge clk);
        chk("drain_idle", cpu_stall, 0);
        base = dones;
        chk("random_dumps_whole", got.size(), base * NWORDS);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
